// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: streams an IMG_W x IMG_H RGB332 image from pixel memory through a
// small prefetch FIFO and presents it as 4:4:4 colour at (X0,Y0) of the active area.
// Everything outside the image is BG_COLOUR; a starved FIFO inside the image shows
// UNDER_COLOUR and latches the sticky underrun flag.
`timescale 1ns/1ps

module vga_pixel_fetch #(
  parameter int          IMG_W        = 80,
  parameter int          IMG_H        = 80,
  parameter int          X0           = 280,
  parameter int          Y0           = 200,
  parameter int          BASE_ADDR    = 0,
  parameter int          ADDR_W       = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [11:0] BG_COLOUR    = 12'hFFF,
  parameter logic [11:0] UNDER_COLOUR = 12'hF0F
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              pix_en,
  input  logic              de,
  input  logic              frame_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b,
  output logic              underrun,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int FC_W  = $clog2(TOTAL + 1);

  localparam logic [9:0]        X_LO     = 10'(X0);
  localparam logic [9:0]        X_HI     = 10'(X0 + IMG_W);
  localparam logic [9:0]        Y_LO     = 10'(Y0);
  localparam logic [9:0]        Y_HI     = 10'(Y0 + IMG_H);
  localparam logic [FC_W-1:0]   LAST_REQ = FC_W'(TOTAL - 1);
  localparam logic [FC_W-1:0]   TOTAL_C  = FC_W'(TOTAL);
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetchState_t;

  fetchState_t r_state;
  fetchState_t w_stateNext;

  // Pixel position and output registers
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic              r_prevDe;
  logic [3:0]        r_red;
  logic [3:0]        r_grn;
  logic [3:0]        r_blu;
  logic              r_underrun;

  // Prefetch FIFO
  logic [7:0]        r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [CNT_W-1:0]  r_fifoCount;

  // Memory request side
  logic              r_memReq;
  logic [ADDR_W-1:0] r_memAddr;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_discardCnt;
  logic [FC_W-1:0]   r_fetchCount;

  logic              w_inImage;
  logic              w_gnt;
  logic              w_ret;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic [7:0]        w_head;
  logic [CNT_W-1:0]  w_fifoNext;
  logic [CNT_W-1:0]  w_outNext;
  logic [CNT_W-1:0]  w_discardNext;
  logic [FC_W-1:0]   w_fetchNext;
  logic [ADDR_W-1:0] w_addrNext;
  logic [CNT_W:0]    w_occNext;
  logic              w_reqNext;

  // RGB332 to 4:4:4 by replicating the top bits into the low bits.
  function automatic logic [11:0] expandRgb332(input logic [7:0] d);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

  assign w_inImage = (r_x >= X_LO) && (r_x < X_HI) && (r_y >= Y_LO) && (r_y < Y_HI);
  assign w_head    = r_fifoMem[r_rdPtr];

  // A return with nothing outstanding is spurious (e.g. a read issued before clr) and is ignored.
  assign w_gnt  = r_memReq & mem_gnt;
  assign w_ret  = mem_rvalid & (r_outstanding != '0);
  assign w_drop = w_ret & (r_discardCnt != '0);
  assign w_push = w_ret & ~w_drop & ~frame_start;
  assign w_pop  = pix_en & de & w_inImage & (r_fifoCount != '0);

  // Next values of the fetch bookkeeping; frame_start restarts from BASE_ADDR and turns every
  // read still in flight (including one granted this very clock) into a discard.
  always_comb begin
    w_outNext     = r_outstanding + CNT_W'(w_gnt) - CNT_W'(w_ret);
    w_fifoNext    = r_fifoCount + CNT_W'(w_push) - CNT_W'(w_pop);
    w_discardNext = r_discardCnt - CNT_W'(w_drop);
    w_fetchNext   = r_fetchCount + FC_W'(w_gnt);
    w_addrNext    = r_memAddr + ADDR_W'(w_gnt);
    if (frame_start) begin
      w_fifoNext    = '0;
      w_discardNext = w_outNext;
      w_fetchNext   = '0;
      w_addrNext    = BASE_C;
    end
    w_occNext = {1'b0, w_fifoNext} + {1'b0, w_outNext};
    if (r_memReq && !mem_gnt && !frame_start) begin
      w_reqNext = 1'b1;
    end else begin
      w_reqNext = (w_stateNext == FETCH) && (w_discardNext == '0) &&
                  (w_occNext < DEPTH_C) && (w_fetchNext < TOTAL_C);
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Fetch FSM next state: frame_start restarts from any state.
  always_comb begin
    w_stateNext = r_state;
    if (frame_start) begin
      w_stateNext = FETCH;
    end else begin
      case (r_state)
        FETCH:   if (w_gnt && (r_fetchCount == LAST_REQ)) w_stateNext = DRAIN;
        DRAIN:   if (r_outstanding == '0) w_stateNext = DONE;
        default: w_stateNext = r_state;
      endcase
    end
  end

  // Fetch FSM outputs.
  always_comb begin
    busy = (r_state == FETCH) || (r_state == DRAIN);
  end

  // Request, address and in-flight counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_memReq      <= 1'b0;
      r_memAddr     <= BASE_C;
      r_outstanding <= '0;
      r_discardCnt  <= '0;
      r_fetchCount  <= '0;
    end else begin
      r_memReq      <= w_reqNext;
      r_memAddr     <= w_addrNext;
      r_outstanding <= w_outNext;
      r_discardCnt  <= w_discardNext;
      r_fetchCount  <= w_fetchNext;
    end
  end

  // FIFO pointers and occupancy; frame_start empties it.
  always_ff @(posedge clk) begin
    if (clr || frame_start) begin
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_fifoCount <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_fifoCount <= w_fifoNext;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_fifoMem[r_wrPtr] <= mem_rdata;
  end

  // Active-pixel position: x counts de pixels, a falling de ends the line.
  always_ff @(posedge clk) begin
    if (clr || frame_start) begin
      r_x      <= '0;
      r_y      <= '0;
      r_prevDe <= 1'b0;
    end else if (pix_en) begin
      r_prevDe <= de;
      if (de) begin
        r_x <= r_x + 10'd1;
      end else if (r_prevDe) begin
        r_x <= '0;
        r_y <= r_y + 10'd1;
      end
    end
  end

  // Registered colour, one pixel tick behind the de sample; underrun is sticky until clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_red      <= '0;
      r_grn      <= '0;
      r_blu      <= '0;
      r_underrun <= 1'b0;
    end else if (pix_en) begin
      if (!de) begin
        {r_red, r_grn, r_blu} <= 12'h000;
      end else if (w_inImage) begin
        if (r_fifoCount != '0) begin
          {r_red, r_grn, r_blu} <= expandRgb332(w_head);
        end else begin
          {r_red, r_grn, r_blu} <= UNDER_COLOUR;
          r_underrun            <= 1'b1;
        end
      end else begin
        {r_red, r_grn, r_blu} <= BG_COLOUR;
      end
    end
  end

  assign mem_req  = r_memReq;
  assign mem_addr = r_memAddr;
  assign r        = r_red;
  assign g        = r_grn;
  assign b        = r_blu;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: drives a compressed VGA raster (200 one-pixel lines, then a 400-pixel
// line 200) with a pixel strobe every 4th clock, models a pixel memory with adjustable grant
// and read latency, and scoreboards every pixel tick against hand-derived colours.
`timescale 1ns/1ps

module tb_vga_pixel_fetch;

  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        clr;
  logic        pix_en;
  logic        de;
  logic        frame_start;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        underrun;
  logic        busy;

  typedef struct {
    bit          chk;
    logic [11:0] rgb;
    int          x;
    int          y;
  } expPix_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } memRd_t;

  expPix_t     expQ[$];
  memRd_t      pending[$];

  int          testsRun = 0;
  int          testsFailed = 0;
  int          latency = 1;
  int          grantsTaken = 0;
  int          grantLimit = 32'h7fffffff;
  int          firstCheckIdx = -1;
  int          cyc = 0;
  bit          e3Mode = 1'b0;
  bit          holdCheck = 1'b0;
  logic [7:0]  salt = 8'h00;

  vga_pixel_fetch dut (
    .clk         (clk),
    .clr         (clr),
    .pix_en      (pix_en),
    .de          (de),
    .frame_start (frame_start),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .r           (r),
    .g           (g),
    .b           (b),
    .underrun    (underrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] expand332(input logic [7:0] d);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

  function automatic logic [7:0] memByte(input logic [15:0] a);
    if (e3Mode && a == 16'd0) return 8'hE3;
    return a[7:0] ^ salt;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One pixel tick every 4 clocks; the expected colour is queued for the monitor.
  task automatic applyStimulus(input bit deVal, input logic [11:0] rgb, input int x, input int y);
    expPix_t e;
    e.chk = 1'b1;
    e.rgb = rgb;
    e.x   = x;
    e.y   = y;
    @(negedge clk);
    pix_en = 1'b1;
    de     = deVal;
    expQ.push_back(e);
    @(negedge clk);
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulseFrameStart();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // mode 0: normal image row; mode 1: memory stalls for 500 clocks around the image.
  task automatic runRows(input int mode);
    logic [11:0] ex;
    int idx;
    for (int y = 0; y < 200; y++) begin
      applyStimulus(1'b1, 12'hFFF, 0, y);
      applyStimulus(1'b0, 12'h000, 1, y);
    end
    for (int x = 0; x < 400; x++) begin
      if (mode == 1 && x == 250) begin
        grantLimit = grantsTaken;
        holdCheck  = 1'b1;
      end
      if (mode == 1 && x == 375) begin
        checkOutput("stalled req", 32'(mem_req), 32'd1);
        checkOutput("stalled addr", 32'(mem_addr), 32'd8);
        holdCheck  = 1'b0;
        grantLimit = 32'h7fffffff;
      end
      if (x >= 280 && x < 360) begin
        idx = x - 280;
        if (mode == 1 && idx >= 8) ex = 12'hF0F;
        else if (e3Mode && idx == 0) ex = 12'hF0F;
        else ex = expand332(memByte(16'(idx)));
      end else begin
        ex = 12'hFFF;
      end
      applyStimulus(1'b1, ex, x, 200);
    end
    applyStimulus(1'b0, 12'h000, 400, 200);
  endtask

  // Monitor: each pixel tick produces one registered colour, compared at the next negedge.
  initial begin
    expPix_t e;
    forever begin
      @(posedge clk);
      if (pix_en === 1'b1 && clr === 1'b0) begin
        @(negedge clk);
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL scoreboard: pixel output with no expectation queued");
        end else begin
          e = expQ.pop_front();
          if (e.chk) checkOutput($sformatf("pix x=%0d y=%0d", e.x, e.y), 32'({r, g, b}), 32'(e.rgb));
        end
      end
    end
  end

  // Pixel memory model: grants per grantLimit, returns data in order after 'latency' clocks.
  initial begin
    memRd_t      m;
    logic        prevReq;
    logic        prevGnt;
    logic [15:0] prevAddr;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    prevReq    = 1'b0;
    prevGnt    = 1'b0;
    prevAddr   = 16'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (clr === 1'b1) begin
        pending.delete();
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        prevReq    = 1'b0;
        continue;
      end
      if (holdCheck && prevReq && !prevGnt) begin
        checkOutput("req held", 32'(mem_req), 32'd1);
        checkOutput("addr held", 32'(mem_addr), 32'(prevAddr));
      end
      mem_rvalid = 1'b0;
      if (pending.size() > 0 && pending[0].due <= cyc) begin
        m          = pending.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata  = m.data;
      end
      mem_gnt = (grantsTaken < grantLimit);
      if (mem_req && mem_gnt) begin
        if (grantsTaken == firstCheckIdx) checkOutput("first addr after flush", 32'(mem_addr), 32'd0);
        m.data = memByte(mem_addr);
        m.due  = cyc + latency;
        pending.push_back(m);
        grantsTaken++;
        checkOutput("outstanding bound", 32'(pending.size() <= FIFO_DEPTH), 32'd1);
      end
      prevReq  = mem_req;
      prevGnt  = mem_gnt;
      prevAddr = mem_addr;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks so far", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    bit sawReq;
    clr         = 1'b1;
    pix_en      = 1'b0;
    de          = 1'b0;
    frame_start = 1'b1;
    repeat (3) @(negedge clk);
    frame_start = 1'b0;
    checkOutput("reset rgb", 32'({r, g, b}), 32'd0);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset underrun", 32'(underrun), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("idle no req", 32'(mem_req), 32'd0);
    checkOutput("idle busy", 32'(busy), 32'd0);

    // Identity data: image bytes 0..79 on row 200
    pulseFrameStart();
    checkOutput("busy in fetch", 32'(busy), 32'd1);
    runRows(0);
    checkOutput("underrun after clean frame", 32'(underrun), 32'd0);

    // 8'hE3 at BASE_ADDR
    e3Mode = 1'b1;
    pulseFrameStart();
    runRows(0);
    e3Mode = 1'b0;
    checkOutput("underrun after E3 frame", 32'(underrun), 32'd0);

    // Memory stall mid-frame
    pulseFrameStart();
    runRows(1);
    checkOutput("underrun after stall", 32'(underrun), 32'd1);

    // Read latency 6; underrun must survive the frame_start
    latency = 6;
    pulseFrameStart();
    checkOutput("underrun sticky over frame_start", 32'(underrun), 32'd1);
    runRows(0);
    checkOutput("underrun still sticky", 32'(underrun), 32'd1);

    // frame_start with 3 reads in flight: their (old-salt) data must be dropped
    latency    = 12;
    grantLimit = grantsTaken + 3;
    pulseFrameStart();
    repeat (6) @(negedge clk);
    checkOutput("reads in flight", 32'(pending.size()), 32'd3);
    salt = 8'h5A;
    pulseFrameStart();
    firstCheckIdx = grantsTaken;
    grantLimit    = 32'h7fffffff;
    runRows(0);

    // clr mid-FETCH
    latency = 1;
    pulseFrameStart();
    repeat (4) @(negedge clk);
    checkOutput("busy before clr", 32'(busy), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    checkOutput("clr mem_req", 32'(mem_req), 32'd0);
    checkOutput("clr busy", 32'(busy), 32'd0);
    checkOutput("clr rgb", 32'({r, g, b}), 32'd0);
    checkOutput("clr underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    sawReq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sawReq |= mem_req;
    end
    checkOutput("no req after clr", 32'(sawReq), 32'd0);
    checkOutput("addr after clr", 32'(mem_addr), 32'd0);

    repeat (8) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
